mem_wb_stage: RTL

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mips_pkg.sv | 15 +
 rtl/mem_wb_register.sv | 39 +++
 rtl/mem_wb_stage.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MEM/WB stage: FSM states, datapath widths and
// the hard-wired zero register index.
package mips_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register. A cycle without a completing instruction loads a
// bubble, so each instruction is presented on the write port for one cycle.
// Writes to the zero register are suppressed here.
module mem_wb_register
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic              i_reg_write,
    input  logic [REG_W-1:0]  i_write_reg,
    input  logic [DATA_W-1:0] i_write_data,
    output logic              o_reg_write,
    output logic [REG_W-1:0]  o_write_reg,
    output logic [DATA_W-1:0] o_write_data
);

    logic              r_reg_write;
    logic [REG_W-1:0]  r_write_reg;
    logic [DATA_W-1:0] r_write_data;

    // Capture a completing instruction, otherwise insert an all-zero bubble.
    always_ff @(posedge clk) begin
        if (rst || !i_valid) begin
            r_reg_write  <= 1'b0;
            r_write_reg  <= ZERO_REG;
            r_write_data <= '0;
        end else begin
            r_reg_write  <= i_reg_write && (i_write_reg != ZERO_REG);
            r_write_reg  <= i_write_reg;
            r_write_data <= i_write_data;
        end
    end

    assign o_reg_write  = r_reg_write;
    assign o_write_reg  = r_write_reg;
    assign o_write_data = r_write_data;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage controller plus MEM/WB register. Non-memory instructions pass to
// WB with one cycle of latency; loads/stores park in ACCESS until dmem_ready,
// stalling the upstream EX/MEM slot meanwhile.
// Optional build macro MEM_TIMEOUT_EN adds an access watchdog and the sticky
// mem_err output; without it, ACCESS waits indefinitely.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_write_reg,
    input  logic              ex_reg_write,
    input  logic              ex_mem_to_reg,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    output logic              ex_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic              wb_reg_write,
    output logic [REG_W-1:0]  wb_write_reg,
    output logic [DATA_W-1:0] wb_write_data,
    output logic              mem_fwd_valid,
    output logic [REG_W-1:0]  mem_fwd_reg,
    output logic [DATA_W-1:0] mem_fwd_data
`ifdef MEM_TIMEOUT_EN
    ,
    output logic              mem_err
`endif
);

    mem_state_e        r_state;
    logic              r_dmem_req;
    logic              r_dmem_we;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [REG_W-1:0]  r_write_reg;
    logic              r_reg_write;
    logic              r_is_load;

    logic              w_idle;
    logic              w_access;
    logic              w_is_mem;
    logic              w_accept_mem;
    logic              w_timeout;
    logic              w_finish;
    logic              w_wb_valid;
    logic              w_wb_reg_write;
    logic [REG_W-1:0]  w_wb_write_reg;
    logic [DATA_W-1:0] w_wb_write_data;

    assign w_idle       = (r_state == ST_IDLE);
    assign w_access     = (r_state == ST_ACCESS);
    assign w_is_mem     = ex_mem_read || ex_mem_write;
    assign w_accept_mem = w_idle && ex_valid && w_is_mem;
    assign w_finish     = w_access && (dmem_ready || w_timeout);

    // Select what the WB register captures this cycle; anything else is a bubble.
    always_comb begin
        w_wb_valid      = 1'b0;
        w_wb_reg_write  = 1'b0;
        w_wb_write_reg  = ZERO_REG;
        w_wb_write_data = '0;
        if (w_idle && ex_valid && !w_is_mem) begin
            w_wb_valid      = 1'b1;
            w_wb_reg_write  = ex_reg_write;
            w_wb_write_reg  = ex_write_reg;
            w_wb_write_data = ex_mem_to_reg ? dmem_rdata : ex_alu_result;
        end else if (w_access && dmem_ready && r_is_load) begin
            // A completing load always writes back its memory data.
            w_wb_valid      = 1'b1;
            w_wb_reg_write  = r_reg_write || r_is_load;
            w_wb_write_reg  = r_write_reg;
            w_wb_write_data = dmem_rdata;
        end
    end

    // Hold upstream while a memory op is being accepted or is still waiting.
    assign ex_stall = w_accept_mem || (w_access && !dmem_ready && !w_timeout);

    // IDLE/ACCESS controller; latches the memory op and drives the dmem request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_dmem_req  <= 1'b0;
            r_dmem_we   <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_write_reg <= ZERO_REG;
            r_reg_write <= 1'b0;
            r_is_load   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept_mem) begin
                        r_state     <= ST_ACCESS;
                        r_dmem_req  <= 1'b1;
                        // Read wins when both read and write are flagged.
                        r_dmem_we   <= ex_mem_write && !ex_mem_read;
                        r_is_load   <= ex_mem_read;
                        r_addr      <= ex_alu_result;
                        r_wdata     <= ex_store_data;
                        r_write_reg <= ex_write_reg;
                        r_reg_write <= ex_reg_write;
                    end
                end
                ST_ACCESS: begin
                    if (w_finish) begin
                        r_state    <= ST_IDLE;
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_dmem_req <= 1'b0;
                    r_dmem_we  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_mem_err;

    // Abort on the last allowed ACCESS cycle unless ready arrives in it.
    assign w_timeout = w_access && !dmem_ready &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Count ACCESS cycles and latch a sticky error on watchdog abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            r_mem_err <= 1'b0;
        end else begin
            if (w_access && !w_finish) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end else begin
                r_tmo_cnt <= '0;
            end
            if (w_timeout) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    assign mem_err = r_mem_err;
`else
    assign w_timeout = 1'b0;
`endif

    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;

    assign mem_fwd_valid = ex_valid && ex_reg_write && !ex_mem_read &&
                           (ex_write_reg != ZERO_REG);
    assign mem_fwd_reg   = ex_write_reg;
    assign mem_fwd_data  = ex_alu_result;

    mem_wb_register u_wb_reg (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (w_wb_valid),
        .i_reg_write  (w_wb_reg_write),
        .i_write_reg  (w_wb_write_reg),
        .i_write_data (w_wb_write_data),
        .o_reg_write  (wb_reg_write),
        .o_write_reg  (wb_write_reg),
        .o_write_data (wb_write_data)
    );

endmodule
